// File: rtl/serial_add_sub_if.sv
// Handshake and operand/result bundle for serial_add_sub.
// master = controller issuing operations, slave = the adder/subtractor.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor, DIGIT bits per clock with a registered carry.
// Optional macro SERIAL_ADD_SUB_SAT_EN saturates sum on signed overflow.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | one digit processed per clock, busy high
// S_DONE | result registers just loaded, done high for this cycle
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic             clk,
  input logic             rst,
  serial_add_sub_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] opa, opb, res, res_nx, sum_nx;
  logic [CW-1:0]    cnt;
  logic             carry, mode_q;
  logic [DIGIT-1:0] dsum;
  logic             dcarry, cmsb, last, load;

  assign {dcarry, dsum} = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]}
                        + {{DIGIT{1'b0}}, carry};
  // Carry into the MSB recovered from the sum bit, valid on the last digit.
  assign cmsb = dsum[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];
  assign last = (cnt == CW'(NDIG - 1));
  assign load = bus.start && (state != S_RUN);

  generate
    if (NDIG == 1) begin : g_single
      assign res_nx = dsum;
    end else begin : g_multi
      assign res_nx = {dsum, res[WIDTH-1:DIGIT]};
    end
  endgenerate

`ifdef SERIAL_ADD_SUB_SAT_EN
  // Both effective operands share a sign on overflow; opa's MSB gives the direction.
  assign sum_nx = (cmsb ^ dcarry)
                ? (opa[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                : res_nx;
`else
  assign sum_nx = res_nx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      S_IDLE: if (bus.start) state_nx = S_RUN;
      S_RUN: begin
        bus.busy = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_nx = bus.start ? S_RUN : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa          <= '0;
      opb          <= '0;
      res          <= '0;
      carry        <= 1'b0;
      mode_q       <= 1'b0;
      cnt          <= '0;
      bus.sum      <= '0;
      bus.cout     <= 1'b0;
      bus.overflow <= 1'b0;
    end else if (load) begin
      opa    <= bus.a;
      opb    <= bus.mode ? ~bus.b : bus.b;
      carry  <= bus.mode ? ~bus.cin : bus.cin;
      mode_q <= bus.mode;
      cnt    <= '0;
    end else if (state == S_RUN) begin
      opa   <= opa >> DIGIT;
      opb   <= opb >> DIGIT;
      res   <= res_nx;
      carry <= dcarry;
      cnt   <= cnt + 1'b1;
      if (last) begin
        bus.sum      <= sum_nx;
        bus.cout     <= mode_q ? ~dcarry : dcarry;
        bus.overflow <= cmsb ^ dcarry;
      end
    end
  end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Multi-cycle, parametrised adder/subtractor that processes DIGIT bits per clock using a registered carry. It is the sequential successor to the single-bit full adder and trades latency for area in wide datapaths. A start/busy/done handshake lets a controller issue one operation at a time. Results hold stable until the next operation completes.

Parameters:
WIDTH, 8, operand/result width in bits; must be ≥ 2.
DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. NDIG = WIDTH/DIGIT.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE or DONE
mode  input  1  0 = add, 1 = subtract; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
cin  input  1  carry-in (add) or borrow-in (sub); sampled with start
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse when the result registers update
sum  output  WIDTH  result of the last completed operation
cout  output  1  add: carry-out; sub: borrow-out (inverted final carry)
overflow  output  1  two's-complement signed overflow of the last result

Behaviour:
- Reset (asynchronous, any state): state = IDLE; busy, done, sum, cout and overflow = 0; internal shift registers, carry and digit counter = 0.
- States: IDLE, RUN, DONE.
- IDLE: start = 1 at an edge latches a into opA and (mode ? ~b : b) into opB. Initial carry = (mode ? ~cin : cin). Counter = 0. Go to RUN.
- RUN: each edge adds the low DIGIT bits of opA, opB and carry. The DIGIT-bit result shifts into the top of the result shift register. opA and opB shift right by DIGIT. Carry takes the digit carry-out and the counter increments. On the edge that processes digit NDIG-1, go to DONE.
- The result registers load on that same edge:
  - sum = result shift register.
  - cout = final carry when mode = 0; ~final carry when mode = 1.
  - overflow = carry into MSB XOR carry out of MSB.
- Add result is a + b + cin. Sub result is a − b − cin, modulo 2^WIDTH.
- DONE: done = 1 for exactly this cycle. Next edge: go to RUN if start = 1 (back-to-back, new operands latched), else go to IDLE.
- Latency: start sampled at edge E0; done is high in the cycle after edge E(NDIG); sum is valid from that same cycle.
- start during RUN is ignored; no queuing.
- busy = 1 in RUN only. busy and done are never high together.
- sum, cout and overflow change only on the completion edge or on reset.
- Input changes after the start edge have no effect on the operation in flight.

Optional Feature:
Macro SERIAL_ADD_SUB_SAT_EN.
- Defined: on signed overflow, sum loads the saturated value. Positive overflow gives {0,1…1}; negative overflow gives {1,0…0}. overflow and cout are still reported unmodified.
- Undefined: sum is the wrapped modulo result.

Test Plan:
1. WIDTH = 8, DIGIT = 1. Add 100 + 27, cin = 0 → sum = 8'd127, cout = 0, overflow = 0. busy high for 8 cycles; done pulses in the cycle after the 9th edge counting the start edge (E0..E8).
2. Add 8'hFF + 8'h01, cin = 0 → sum = 8'h00, cout = 1, overflow = 0. Add 8'h7F + 8'h01 → sum = 8'h80, overflow = 1. With SERIAL_ADD_SUB_SAT_EN defined, the second case gives sum = 8'h7F.
3. Sub 5 − 7, cin = 0 → sum = 8'hFE, cout (borrow) = 1, overflow = 0. Sub 8'h80 − 8'h01 → sum = 8'h7F, overflow = 1; saturated build gives sum = 8'h80.
4. During RUN, pulse start with new operands → ignored; the original result completes. Hold start high in the DONE cycle → second operation begins immediately, with no IDLE cycle.
5. Assert rst at the 4th RUN cycle → busy, done, sum, cout and overflow = 0 immediately (asynchronous). Release rst; done never pulses for the aborted operation. A new start (3 + 4) → sum = 8'd7.
6. WIDTH = 8, DIGIT = 4. Add 8'h3C + 8'h0F, cin = 1 → sum = 8'h4C after 2 RUN cycles, done in the cycle after edge E2. WIDTH = 16, DIGIT = 8: sub 16'h0000 − 16'h0001 → sum = 16'hFFFF, cout = 1.
